draw_sprite: RTL and testbench

Parametrised ROM-backed sprite overlay stage for the VGA pixel pipeline. It sits between two `vga_if` stages, like the other draw stages. It overlays a `SPRITE_W` x `SPRITE_H` image, read from an external synchronous ROM, at a position latched once per frame, and passes all other pixels through. It compensates for ROM read latency so sprite pixels and timing signals stay aligned. A keyed colour can optionally be treated as transparent.

---
 rtl/draw_sprite_if.sv | 21 ++
 rtl/draw_sprite.sv | 172 +++++++++++++++++
 tb/tb_draw_sprite.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/draw_sprite_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Interface : vga_if
// Purpose   : VGA pixel-stream bundle (timing, blanking and colour) passed
//             between draw stages. Modport 'in' for a stage's upstream side,
//             'out' for its downstream side.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_sprite.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : draw_sprite
// Purpose  : Overlays a SPRITE_W x SPRITE_H image fetched from an external
//            synchronous ROM onto the VGA stream. The sprite position and
//            visibility are latched once per frame at the vblnk rising edge.
//            Timing fields are delayed to match the ROM read latency, giving
//            a fixed ROM_LATENCY+2 cycle latency for every field.
// Options  : DRAW_SPRITE_TRANSPARENCY_EN - when defined, ROM pixels equal to
//            TRANSPARENT show the background instead.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module draw_sprite #(
  parameter int          SPRITE_W    = 100,
  parameter int          SPRITE_H    = 100,
  parameter int          ADDR_W      = 14,
  parameter int          ROM_LATENCY = 1,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  wire logic              clk,
  input  wire logic              rst,
  vga_if.in                      vga_in,
  vga_if.out                     vga_out,
  input  wire logic [11:0]       xpos,
  input  wire logic [11:0]       ypos,
  input  wire logic              en,
  output logic      [ADDR_W-1:0] rom_addr,
  input  wire logic [11:0]       rom_data
);

  localparam int PIPE_N = 1 + ROM_LATENCY;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t px;
    logic hit;
  } pix_t;

  // Frame-latched sprite placement
  logic        vblnk_q;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic        en_q;
  logic        frame_start;

  assign frame_start = vga_in.vblnk & ~vblnk_q;

  // Capture requested placement only at the frame boundary to avoid tearing
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      vblnk_q <= vga_in.vblnk;
      if (frame_start) begin
        x_q  <= xpos;
        y_q  <= ypos;
        en_q <= en;
      end
    end
  end

  // Hit test: 13-bit end bounds so a sprite near column/row 4095 does not wrap
  logic [12:0] x_end;
  logic [12:0] y_end;
  logic        hit;

  assign x_end = {1'b0, x_q} + 13'(SPRITE_W);
  assign y_end = {1'b0, y_q} + 13'(SPRITE_H);

  assign hit = en_q & ~vga_in.hblnk & ~vga_in.vblnk
             & (vga_in.hcount >= x_q) & ({1'b0, vga_in.hcount} < x_end)
             & (vga_in.vcount >= y_q) & ({1'b0, vga_in.vcount} < y_end);

  // Per-pixel linear address; computed fresh each pixel so clipping is harmless
  logic [11:0]       off_x;
  logic [11:0]       off_y;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [ADDR_W-1:0] rom_addr_q;

  assign off_x = vga_in.hcount - x_q;
  assign off_y = vga_in.vcount - y_q;

  // Next ROM address: new sprite offset on a hit, otherwise hold
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (hit) begin
      rom_addr_d = ADDR_W'(off_y) * ADDR_W'(SPRITE_W) + ADDR_W'(off_x);
    end
  end

  // ROM address register
  always_ff @(posedge clk) begin
    if (rst) rom_addr_q <= '0;
    else     rom_addr_q <= rom_addr_d;
  end

  assign rom_addr = rom_addr_q;

  // Alignment pipeline: one stage for the address register plus ROM_LATENCY
  pix_t stage_in;
  pix_t pipe_q [PIPE_N];

  assign stage_in.px.hcount = vga_in.hcount;
  assign stage_in.px.vcount = vga_in.vcount;
  assign stage_in.px.hsync  = vga_in.hsync;
  assign stage_in.px.vsync  = vga_in.vsync;
  assign stage_in.px.hblnk  = vga_in.hblnk;
  assign stage_in.px.vblnk  = vga_in.vblnk;
  assign stage_in.px.rgb    = vga_in.rgb;
  assign stage_in.hit       = hit;

  // Shift pixel and hit flag through the delay stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < PIPE_N; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Colour-key decision
  pix_t last;
  logic opaque;

  assign last = pipe_q[PIPE_N-1];

`ifdef DRAW_SPRITE_TRANSPARENCY_EN
  assign opaque = (rom_data != TRANSPARENT);
`else
  logic unused_key;
  assign unused_key = ^TRANSPARENT;
  assign opaque     = 1'b1;
`endif

  vga_t out_d;
  vga_t out_q;

  // Output pixel: sprite colour on an opaque hit, background otherwise
  always_comb begin
    out_d = last.px;
    if (last.hit && opaque) out_d.rgb = rom_data;
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_draw_sprite
// Purpose  : Scoreboard bench for draw_sprite. A driver issues one pixel per
//            clock (directed scenarios, then random), a reference model
//            pushes the expected output pixel and ROM address, and a monitor
//            pops and compares them when they are due.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_draw_sprite;

  localparam int SW = 100;
  localparam int SH = 100;
  localparam int AW = 14;
`ifdef DRAW_SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   xpos = 12'd200;
  logic [11:0]   ypos = 12'd150;
  logic          en   = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  draw_sprite dut (
    .clk      (clk),
    .rst      (rst),
    .vga_in   (vin),
    .vga_out  (vout),
    .xpos     (xpos),
    .ypos     (ypos),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  // ROM image: low 10 address bits, with a colour-key pixel at address 5
  function automatic logic [11:0] rom_f(input int a);
    if (a == 5) return 12'hF0F;
    return 12'(a % 1024);
  endfunction

  always @(posedge clk) rom_data <= rom_f(int'(rom_addr));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [39:0] v; } exp_t;
  typedef struct { int due; logic [AW-1:0] a; } aexp_t;
  exp_t  q[$];
  aexp_t aq[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: placement as seen by the drawn frame
  int mx = 0, my = 0, maddr = 0;
  bit men = 0, mvb = 0;

  task automatic drive(input int h, input int v, input bit r);
    logic [11:0] bg, pix;
    bit hb, vb, hs, vs, hit;
    int n;
    @(negedge clk);
    bg = 12'($urandom);
    hb = (h >= 1024);
    vb = (v >= 768);
    hs = (h >= 1048 && h < 1184);
    vs = (v >= 771 && v < 777);
    rst = r;
    vin.hcount = 12'(h);
    vin.vcount = 12'(v);
    vin.hsync = hs;
    vin.vsync = vs;
    vin.hblnk = hb;
    vin.vblnk = vb;
    vin.rgb = bg;
    n = cyc;
    if (r) begin
      // Reset flushes everything still in flight
      foreach (q[i]) if (q[i].due > n) q[i].v = '0;
      q.push_back('{due: n + 3, v: 40'd0});
      aq.push_back('{due: n + 1, a: '0});
      mx = 0; my = 0; men = 0; mvb = 0; maddr = 0;
    end else begin
      hit = men && !hb && !vb && h >= mx && h < mx + SW && v >= my && v < my + SH;
      if (hit) maddr = ((v - my) * SW + (h - mx)) % (1 << AW);
      pix = bg;
      if (hit && !(TRANSP && rom_f(maddr) == 12'hF0F)) pix = rom_f(maddr);
      q.push_back('{due: n + 3, v: {12'(h), 12'(v), hs, vs, hb, vb, pix}});
      aq.push_back('{due: n + 1, a: AW'(maddr)});
      if (vb && !mvb) begin
        mx = int'(xpos); my = int'(ypos); men = en;
      end
      mvb = vb;
    end
  endtask

  task automatic rnd(input int n, input int hlo, input int hhi, input int vlo, input int vhi);
    for (int i = 0; i < n; i++)
      drive(int'($urandom_range(hhi, hlo)), int'($urandom_range(vhi, vlo)), 1'b0);
  endtask

  // Monitor: compare whatever is due this cycle
  initial begin
    exp_t  e;
    aexp_t ea;
    logic [39:0] got;
    forever begin
      @(posedge clk);
      #1;
      while (aq.size() > 0 && aq[0].due <= cyc) begin
        ea = aq.pop_front();
        checks++;
        if (ea.due != cyc || rom_addr !== ea.a) begin
          errors++;
          $display("FAIL rom_addr cyc=%0d due=%0d got=%0d exp=%0d", cyc, ea.due, rom_addr, ea.a);
        end
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        got = {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
               vout.hblnk, vout.vblnk, vout.rgb};
        checks++;
        if (e.due != cyc || got !== e.v) begin
          errors++;
          $display("FAIL pixel cyc=%0d due=%0d got h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h exp h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h",
                   cyc, e.due, got[39:28], got[27:16], got[15], got[14], got[13], got[12], got[11:0],
                   e.v[39:28], e.v[27:16], e.v[15], e.v[14], e.v[13], e.v[12], e.v[11:0]);
        end
      end
    end
  end

  initial begin
    // Reset with en already requested, then passthrough before any vblnk edge
    for (int i = 0; i < 3; i++) drive(int'($urandom_range(1023, 0)), 100, 1'b1);
    rnd(100, 150, 350, 100, 300);

    // Placement at (200,150)
    drive(0, 768, 1'b0);
    drive(0, 0, 1'b0);
    drive(200, 150, 1'b0);
    drive(201, 150, 1'b0);
    drive(200, 151, 1'b0);
    drive(299, 249, 1'b0);
    drive(300, 150, 1'b0);
    drive(199, 150, 1'b0);
    drive(204, 150, 1'b0);
    drive(205, 150, 1'b0);
    drive(206, 150, 1'b0);
    for (int hh = 190; hh < 310; hh++) drive(hh, 200, 1'b0);
    rnd(200, 150, 350, 100, 300);

    // Mid-frame position change is deferred to the next frame
    drive(0, 300, 1'b0);
    xpos = 12'd400;
    rnd(200, 150, 550, 100, 300);
    drive(0, 770, 1'b0);
    rnd(200, 150, 550, 100, 300);

    // Clipping at the right and bottom edges
    xpos = 12'd980; ypos = 12'd700;
    drive(0, 768, 1'b0);
    drive(0, 0, 1'b0);
    drive(1023, 700, 1'b0);
    drive(1030, 700, 1'b0);
    drive(1100, 700, 1'b0);
    drive(980, 701, 1'b0);
    drive(1000, 768, 1'b0);
    rnd(200, 950, 1100, 680, 800);

    // Mid-frame reset, then recovery at the next vblnk edge
    xpos = 12'd200; ypos = 12'd150;
    drive(0, 700, 1'b0);
    drive(0, 768, 1'b0);
    drive(0, 0, 1'b0);
    rnd(20, 150, 350, 100, 300);
    drive(250, 200, 1'b1);
    rnd(50, 150, 350, 100, 300);
    drive(0, 768, 1'b0);
    rnd(50, 150, 350, 100, 300);

    // Random placement, visibility, raster positions and occasional resets
    for (int blk = 0; blk < 15; blk++) begin
      xpos = 12'($urandom_range(1100, 0));
      ypos = 12'($urandom_range(800, 0));
      en   = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(399, 0) == 0)
          drive(int'($urandom_range(1343, 0)), int'($urandom_range(805, 0)), 1'b1);
        else if ($urandom_range(1, 0) == 1)
          drive(mx + int'($urandom_range(120, 0)) - 10, my + int'($urandom_range(120, 0)) - 10, 1'b0);
        else
          drive(int'($urandom_range(1343, 0)), int'($urandom_range(805, 0)), 1'b0);
      end
    end

    // Drain the pipeline, bounded
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0 || aq.size() != 0) begin
      errors++;
      $display("FAIL drain pending pixels=%0d addrs=%0d required=0", q.size(), aq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
